// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a masked irq.
// Optional auto-reload (MODE != 0) is compiled in only when TIMER_AUTO_RELOAD_EN is defined.
module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic        we,
  input  logic [3:0]  be,
  output logic [31:0] readdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_ctrl;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;
  logic             r_irqFlag;

  logic        w_en;
  logic        w_autoReload;
  logic        w_wrCtrl;
  logic        w_wrPreset;
  logic        w_loadCount;
  logic        w_decCount;
  logic        w_zeroCount;
  logic        w_setFlag;
  logic        w_clearEn;
  logic        w_intExit;
  logic [31:0] w_presetWide;
  logic [31:0] w_presetMerged;
  logic        w_unused;

  assign w_en = r_ctrl[0];

`ifdef TIMER_AUTO_RELOAD_EN
  assign w_autoReload = |r_ctrl[2:1];
`else
  assign w_autoReload = 1'b0;
`endif

  // CTRL only has live bits in byte 0, so a CTRL write without be[0] is a no-op.
  assign w_wrCtrl   = we && (addr[3:2] == 2'd0) && be[0];
  assign w_wrPreset = we && (addr[3:2] == 2'd1);
  assign w_unused   = ^{addr[31:4], addr[1:0]};

  assign w_presetWide = 32'(r_preset);

  always_comb begin
    w_presetMerged = w_presetWide;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        w_presetMerged[8*i +: 8] = writedata[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_loadCount = 1'b0;
    w_decCount  = 1'b0;
    w_zeroCount = 1'b0;
    w_setFlag   = 1'b0;
    w_clearEn   = 1'b0;
    w_intExit   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_en) begin
          w_next = LOAD;
        end
      end
      LOAD: begin
        w_loadCount = 1'b1;
        w_next      = CNT;
      end
      CNT: begin
        if (!w_en) begin
          w_next = IDLE;
        end else if (r_count > CNT_W'(1)) begin
          w_decCount = 1'b1;
        end else begin
          w_zeroCount = 1'b1;
          w_setFlag   = 1'b1;
          w_next      = INT;
        end
      end
      INT: begin
        w_intExit = 1'b1;
        // Auto-reload passes straight through to LOAD so the period is PRESET+2.
        if (w_autoReload && w_en) begin
          w_next = LOAD;
        end else begin
          w_next = IDLE;
        end
        if (!w_autoReload) begin
          w_clearEn = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A bus write to CTRL overrides the FSM's EN clear on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl <= 4'd0;
    end else if (w_wrCtrl) begin
      r_ctrl <= writedata[3:0];
    end else if (w_clearEn) begin
      r_ctrl[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_preset <= '0;
    end else if (w_wrPreset) begin
      r_preset <= w_presetMerged[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_loadCount) begin
      r_count <= r_preset;
    end else if (w_decCount) begin
      r_count <= r_count - CNT_W'(1);
    end else if (w_zeroCount) begin
      r_count <= '0;
    end
  end

  // Acknowledge via CTRL wins even against the edge that raises the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irqFlag <= 1'b0;
    end else if (w_wrCtrl) begin
      r_irqFlag <= 1'b0;
    end else if (w_setFlag) begin
      r_irqFlag <= 1'b1;
    end else if (w_intExit && w_autoReload) begin
      r_irqFlag <= 1'b0;
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (addr[3:2])
      2'd0:    readdata = {28'd0, r_ctrl};
      2'd1:    readdata = 32'(r_preset);
      2'd2:    readdata = 32'(r_count);
      default: readdata = 32'd0;
    endcase
  end

  assign irq = r_irqFlag & r_ctrl[3];

endmodule
